// File: rtl/sprite_display_engine.sv
// ---------------------------------------------------------------------------
// sprite_display_engine
//
// Composites NUM_SPRITES movable sprites over a tile-based level background
// and drives registered 12-bit RGB for the VGA path. Each sprite has its own
// enable, colour and hit-flash counter. Sprite position, enable and colour
// are copied into shadow registers on frameStart, so changes made mid-frame
// do not tear the picture. The engine also addresses the synchronous
// level-map memory and hides its one-cycle read latency in a 2-stage pipeline.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   frameStart   one-cycle pulse; latches sprite state, steps flash counters
//   bright       active-video flag aligned with hCount/vCount
//   hCount       current pixel column
//   vCount       current pixel row
//   spritePos    per sprite {X,Y}; X upper half; Y is the sprite's bottom row
//   spriteEn     per-sprite visible flag
//   spriteColor  per-sprite base colour (12 bits each)
//   spriteHit    per-sprite pulse that starts (or restarts) a hit flash
//   tileRow      level-map row address (registered)
//   tileCol      level-map column address (registered)
//   blockType    level-map data, valid one cycle after tileRow/tileCol
//   flashActive  per sprite: flash counter nonzero (registered)
//   rgb          pixel colour (registered)
// ---------------------------------------------------------------------------
module sprite_display_engine #(
    parameter int          NUM_SPRITES  = 4,
    parameter int          COORD_W      = 10,
    parameter int          SPRITE_W     = 32,
    parameter int          SPRITE_H     = 32,
    parameter int          TILE_SHIFT   = 5,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [11:0] FLASH_COLOR  = 12'hF00
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               frameStart,
    input  logic                               bright,
    input  logic [COORD_W-1:0]                 hCount,
    input  logic [COORD_W-1:0]                 vCount,
    input  logic [NUM_SPRITES*2*COORD_W-1:0]   spritePos,
    input  logic [NUM_SPRITES-1:0]             spriteEn,
    input  logic [NUM_SPRITES*12-1:0]          spriteColor,
    input  logic [NUM_SPRITES-1:0]             spriteHit,
    output logic [COORD_W-TILE_SHIFT-1:0]      tileRow,
    output logic [COORD_W-TILE_SHIFT-1:0]      tileCol,
    input  logic [2:0]                         blockType,
    output logic [NUM_SPRITES-1:0]             flashActive,
    output logic [11:0]                        rgb
);

    localparam int CW1 = COORD_W + 1;

    logic [NUM_SPRITES*2*COORD_W-1:0] shPos;
    logic [NUM_SPRITES-1:0]           shEn;
    logic [NUM_SPRITES*12-1:0]        shColor;

    logic [NUM_SPRITES-1:0] hitVec;
    logic [NUM_SPRITES-1:0] flashOdd;
    logic [11:0]            selColor;

    logic [NUM_SPRITES-1:0] hitVecS1;
    logic [11:0]            colorS1;
    logic                   brightS1;

    // Shadow copies of the sprite state. They only move on frameStart so the
    // whole frame is drawn from one consistent snapshot; a frameStart arriving
    // mid-line is still honoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shPos   <= '0;
            shEn    <= '0;
            shColor <= '0;
        end else if (frameStart) begin
            shPos   <= spritePos;
            shEn    <= spriteEn;
            shColor <= spriteColor;
        end
    end

    generate
        for (genvar i = 0; i < NUM_SPRITES; i++) begin : gSprite
            logic [COORD_W-1:0] xVal;
            logic [COORD_W-1:0] yVal;
            logic [CW1-1:0]     xLo;
            logic [CW1-1:0]     xHi;
            logic [CW1-1:0]     yLo;
            logic [CW1-1:0]     yHi;
            logic [7:0]         count;
            logic [7:0]         countNext;

            assign xVal = shPos[(2*i+1)*COORD_W +: COORD_W];
            assign yVal = shPos[2*i*COORD_W +: COORD_W];

            // The bounds are formed one bit wider than the coordinates so the
            // right edge can run past the screen without wrapping to column 0.
            // The top edge is clamped at row 0 instead of going negative, which
            // keeps a sprite near the top from reappearing at the bottom.
            assign xLo = {1'b0, xVal};
            assign xHi = {1'b0, xVal} + CW1'(SPRITE_W - 1);
            assign yHi = {1'b0, yVal};
            assign yLo = ({1'b0, yVal} >= CW1'(SPRITE_H - 1))
                       ? ({1'b0, yVal} - CW1'(SPRITE_H - 1)) : '0;

            assign hitVec[i] = shEn[i]
                             && ({1'b0, hCount} >= xLo) && ({1'b0, hCount} <= xHi)
                             && ({1'b0, vCount} >= yLo) && ({1'b0, vCount} <= yHi);

            // Flash counter next value: a hit (re)loads the full duration and
            // beats a coincident frameStart; otherwise each frame counts down
            // and the counter parks at zero.
            always_comb begin
                countNext = count;
                if (spriteHit[i]) begin
                    countNext = 8'(FLASH_FRAMES);
                end else if (frameStart && (count != 8'd0)) begin
                    countNext = count - 8'd1;
                end
            end

            // The flag is registered from the same next value so it always
            // agrees with the counter it reports on.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count          <= 8'd0;
                    flashActive[i] <= 1'b0;
                end else begin
                    count          <= countNext;
                    flashActive[i] <= (countNext != 8'd0);
                end
            end

            assign flashOdd[i] = count[0];
        end
    endgenerate

    // Priority select: walking from the highest index down lets the lowest
    // hitting index win. An odd flash count swaps in the flash colour, which
    // makes the sprite blink once per frame while the counter runs down.
    always_comb begin
        selColor = 12'h000;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hitVec[i]) begin
                selColor = flashOdd[i] ? FLASH_COLOR : shColor[i*12 +: 12];
            end
        end
    end

    // Stage 1: issue the level-map address and capture everything the final
    // mux needs, so it lines up with blockType returning one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tileRow  <= '0;
            tileCol  <= '0;
            hitVecS1 <= '0;
            colorS1  <= 12'h000;
            brightS1 <= 1'b0;
        end else begin
            tileRow  <= vCount[COORD_W-1:TILE_SHIFT];
            tileCol  <= hCount[COORD_W-1:TILE_SHIFT];
            hitVecS1 <= hitVec;
            colorS1  <= selColor;
            brightS1 <= bright;
        end
    end

    function automatic logic [11:0] paletteColor(input logic [2:0] code);
        logic [11:0] c;
        case (code)
            3'd0:    c = 12'hFFF;
            3'd1:    c = 12'h00F;
            3'd2:    c = 12'h0F0;
            3'd3:    c = 12'h840;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

    // Stage 2: blank outside active video, sprites sit over the background.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb <= 12'h000;
        end else if (!brightS1) begin
            rgb <= 12'h000;
        end else if (|hitVecS1) begin
            rgb <= colorS1;
        end else begin
            rgb <= paletteColor(blockType);
        end
    end

endmodule

// File: tb/tb_sprite_display_engine.sv
// ---------------------------------------------------------------------------
// tb_sprite_display_engine
//
// Directed bench for sprite_display_engine with default parameters. Each
// pixel is presented alone: hCount/vCount/bright, one edge, then blockType,
// one more edge, then rgb is compared against a hand-computed colour.
// ---------------------------------------------------------------------------
module tb_sprite_display_engine;

    localparam int NS = 4;
    localparam int CW = 10;

    logic            clk;
    logic            rst_n;
    logic            frameStart;
    logic            bright;
    logic [CW-1:0]   hCount;
    logic [CW-1:0]   vCount;
    logic [NS*2*CW-1:0] spritePos;
    logic [NS-1:0]   spriteEn;
    logic [NS*12-1:0] spriteColor;
    logic [NS-1:0]   spriteHit;
    logic [4:0]      tileRow;
    logic [4:0]      tileCol;
    logic [2:0]      blockType;
    logic [NS-1:0]   flashActive;
    logic [11:0]     rgb;

    int assertCount = 0;
    int failCount   = 0;

    sprite_display_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frameStart  (frameStart),
        .bright      (bright),
        .hCount      (hCount),
        .vCount      (vCount),
        .spritePos   (spritePos),
        .spriteEn    (spriteEn),
        .spriteColor (spriteColor),
        .spriteHit   (spriteHit),
        .tileRow     (tileRow),
        .tileCol     (tileCol),
        .blockType   (blockType),
        .flashActive (flashActive),
        .rgb         (rgb)
    );

    // Free-running 100 MHz-style clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one pixel, return blockType a cycle later, land after the
    // second edge where rgb for that pixel is valid.
    task automatic applyStimulus(input int h, input int v, input logic [2:0] bt);
        hCount = CW'(h);
        vCount = CW'(v);
        bright = 1'b1;
        @(posedge clk);
        #1;
        blockType = bt;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseFrame();
        frameStart = 1'b1;
        @(posedge clk);
        #1;
        frameStart = 1'b0;
    endtask

    task automatic setSprite(input int i, input int x, input int y, input logic en, input logic [11:0] col);
        spritePos[i*2*CW +: 2*CW] = {CW'(x), CW'(y)};
        spriteEn[i]               = en;
        spriteColor[i*12 +: 12]   = col;
    endtask

    task automatic pixelCheck(input string tag, input int h, input int v, input logic [11:0] exp);
        applyStimulus(h, v, 3'd0);
        checkOutput($sformatf("%s h=%0d v=%0d", tag, h, v), 32'(rgb), 32'(exp));
    endtask

    initial begin
        int cnt;
        rst_n       = 1'b0;
        frameStart  = 1'b0;
        bright      = 1'b0;
        hCount      = '0;
        vCount      = '0;
        spritePos   = '0;
        spriteEn    = '0;
        spriteColor = '0;
        spriteHit   = '0;
        blockType   = 3'd0;

        // ---- Test 1: reset behaviour ----
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("reset rgb", 32'(rgb), 32'h0);
        checkOutput("reset tileRow", 32'(tileRow), 32'h0);
        checkOutput("reset flashActive", 32'(flashActive), 32'h0);

        spriteHit = 4'b1000;
        @(posedge clk);
        #1;
        spriteHit = '0;
        applyStimulus(70, 40, 3'd0);
        checkOutput("pre-reset rgb", 32'(rgb), 32'hFFF);
        checkOutput("pre-reset tileRow", 32'(tileRow), 32'd1);
        checkOutput("pre-reset flashActive", 32'(flashActive), 32'b1000);

        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rgb", 32'(rgb), 32'h0);
        checkOutput("async tileRow", 32'(tileRow), 32'h0);
        checkOutput("async tileCol", 32'(tileCol), 32'h0);
        checkOutput("async flashActive", 32'(flashActive), 32'h0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        bright = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("post-reset dark rgb", 32'(rgb), 32'h0);

        // ---- Test 2: single sprite footprint ----
        setSprite(0, 100, 200, 1'b1, 12'h0AB);
        pulseFrame();
        for (int h = 99; h <= 132; h++) begin
            pixelCheck("sweep", h, 185, (h >= 100 && h <= 131) ? 12'h0AB : 12'hFFF);
        end
        pixelCheck("row169", 110, 169, 12'h0AB);
        pixelCheck("row200", 110, 200, 12'h0AB);
        pixelCheck("row168", 110, 168, 12'hFFF);
        pixelCheck("row201", 110, 201, 12'hFFF);

        // ---- Test 3: priority and shadowing ----
        setSprite(0, 300, 300, 1'b1, 12'h111);
        setSprite(2, 300, 300, 1'b1, 12'h222);
        pulseFrame();
        pixelCheck("prio both", 310, 290, 12'h111);
        spriteEn[0] = 1'b0;
        pixelCheck("prio no frame", 310, 290, 12'h111);
        pulseFrame();
        pixelCheck("prio s2 only", 310, 290, 12'h222);
        setSprite(2, 700, 700, 1'b1, 12'h222);
        pixelCheck("shadow hold", 310, 290, 12'h222);
        pulseFrame();
        pixelCheck("shadow moved", 310, 290, 12'hFFF);

        // ---- Test 4: background palette ----
        spriteEn = '0;
        pulseFrame();
        hCount = CW'(70);
        vCount = CW'(40);
        bright = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("tileRow", 32'(tileRow), 32'd1);
        checkOutput("tileCol", 32'(tileCol), 32'd2);
        blockType = 3'd1;
        @(posedge clk);
        #1;
        checkOutput("palette1", 32'(rgb), 32'h00F);
        applyStimulus(70, 40, 3'd5);
        checkOutput("palette5", 32'(rgb), 32'h000);
        applyStimulus(70, 40, 3'd2);
        checkOutput("palette2", 32'(rgb), 32'h0F0);
        applyStimulus(70, 40, 3'd3);
        checkOutput("palette3", 32'(rgb), 32'h840);
        bright = 1'b1;
        hCount = CW'(70);
        vCount = CW'(40);
        bright = 1'b0;
        @(posedge clk);
        #1;
        blockType = 3'd0;
        @(posedge clk);
        #1;
        checkOutput("blanked", 32'(rgb), 32'h000);

        // ---- Test 5: hit flash ----
        setSprite(1, 600, 400, 1'b1, 12'h0C0);
        pulseFrame();
        spriteHit = 4'b0010;
        @(posedge clk);
        #1;
        spriteHit = '0;
        pixelCheck("flash cnt8", 610, 390, 12'h0C0);
        checkOutput("flashActive cnt8", 32'(flashActive), 32'b0010);
        cnt = 8;
        for (int k = 1; k <= 8; k++) begin
            pulseFrame();
            cnt = cnt - 1;
            pixelCheck($sformatf("flash cnt%0d", cnt), 610, 390, cnt[0] ? 12'hF00 : 12'h0C0);
            checkOutput($sformatf("flashActive cnt%0d", cnt), 32'(flashActive),
                        (cnt != 0) ? 32'b0010 : 32'b0000);
        end
        spriteHit  = 4'b0010;
        frameStart = 1'b1;
        @(posedge clk);
        #1;
        spriteHit  = '0;
        frameStart = 1'b0;
        pixelCheck("coincide cnt8", 610, 390, 12'h0C0);
        checkOutput("coincide active", 32'(flashActive), 32'b0010);
        pulseFrame();
        pixelCheck("coincide cnt7", 610, 390, 12'hF00);
        spriteHit = 4'b0010;
        @(posedge clk);
        #1;
        spriteHit = '0;
        pixelCheck("reload cnt8", 610, 390, 12'h0C0);

        // ---- Test 6: clipping ----
        spriteEn = '0;
        setSprite(0, 500, 10, 1'b1, 12'h5A5);
        setSprite(3, 1000, 200, 1'b1, 12'h3C3);
        pulseFrame();
        pixelCheck("clipY row0", 510, 0, 12'h5A5);
        pixelCheck("clipY row10", 510, 10, 12'h5A5);
        pixelCheck("clipY row11", 510, 11, 12'hFFF);
        pixelCheck("clipY row1000", 510, 1000, 12'hFFF);
        pixelCheck("clipY row1020", 510, 1020, 12'hFFF);
        pixelCheck("clipX col1000", 1000, 190, 12'h3C3);
        pixelCheck("clipX col1023", 1023, 190, 12'h3C3);
        pixelCheck("clipX col999", 999, 190, 12'hFFF);
        pixelCheck("clipX col0", 0, 190, 12'hFFF);
        pixelCheck("clipX col5", 5, 190, 12'hFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
